run_ctrl: RTL and testbench

Run-control sequencer for the processor core. It is the responder side of the host start/done handshake: it holds the core parked at PC 0, launches execution on a falling edge of `start`, and stops the core when the program halts, reaches its last PC, or exceeds a cycle budget. It then asserts `done` and holds it until the host re-arms. It sits in `top_level` between the external `start`/`done` pins and the PC/fetch stage, and gates every architectural state update.

---
 rtl/run_ctrl.sv | 104 ++++++++++
 tb/tb_run_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/run_ctrl.sv
// Run-control sequencer: parks the core at PC 0, launches on a falling edge of
// start, and stops on halt, last PC or cycle budget, then holds done until re-armed.
module run_ctrl #(
  parameter int PROG_LENGTH = 119,
  parameter int PC_W        = 10,
  parameter int CYC_W       = 16,
  parameter int TIMEOUT     = 4096
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [PC_W-1:0]  pc,
  input  logic             halt_i,
  output logic             core_run,
  output logic             pc_clear,
  output logic             done,
  output logic             timeout,
  output logic [CYC_W-1:0] cycles
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARMED,
    S_RUN,
    S_DONE
  } state_t;

  localparam logic [PC_W-1:0]  LP_LAST_PC  = PC_W'(PROG_LENGTH);
  localparam logic [CYC_W-1:0] LP_LAST_CYC = CYC_W'(TIMEOUT - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_start_q;
  logic             r_core_run;
  logic             r_pc_clear;
  logic             r_done;
  logic             r_timeout;
  logic [CYC_W-1:0] r_cycles;
  logic             w_fall;
  logic             w_budget_hit;
  logic             w_launch;

  function automatic logic [CYC_W-1:0] sat_inc(input logic [CYC_W-1:0] v);
    return (&v) ? v : v + CYC_W'(1);
  endfunction

  assign w_fall   = r_start_q & ~start;
  assign w_launch = (r_state == S_ARMED) && (w_state_nxt == S_RUN);

  always_comb begin
    w_state_nxt  = r_state;
    w_budget_hit = 1'b0;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_ARMED;
      S_ARMED: if (w_fall) w_state_nxt = S_RUN;
      S_RUN: begin
        // Abort beats halt/last-PC, which beat the cycle budget.
        if (start) begin
          w_state_nxt = S_ARMED;
        end else if (halt_i || (pc == LP_LAST_PC)) begin
          w_state_nxt = S_DONE;
        end else if (r_cycles == LP_LAST_CYC) begin
          w_state_nxt  = S_DONE;
          w_budget_hit = 1'b1;
        end
      end
      S_DONE:  if (start) w_state_nxt = S_ARMED;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_start_q  <= 1'b1;
      r_core_run <= 1'b0;
      r_pc_clear <= 1'b1;
      r_done     <= 1'b0;
      r_timeout  <= 1'b0;
      r_cycles   <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_start_q  <= start;
      // Outputs are decoded from the next state so they change with the state flop.
      r_core_run <= (w_state_nxt == S_RUN);
      r_pc_clear <= (w_state_nxt == S_IDLE) || (w_state_nxt == S_ARMED);
      r_done     <= (w_state_nxt == S_DONE);
      if (w_launch) begin
        r_cycles  <= '0;
        r_timeout <= 1'b0;
      end else if (r_state == S_RUN) begin
        r_cycles <= sat_inc(r_cycles);
        if (w_state_nxt == S_DONE) r_timeout <= w_budget_hit;
      end
    end
  end

  assign core_run = r_core_run;
  assign pc_clear = r_pc_clear;
  assign done     = r_done;
  assign timeout  = r_timeout;
  assign cycles   = r_cycles;

endmodule

// File: tb/tb_run_ctrl.sv
// Scoreboard bench for run_ctrl: two instances (default budget and a 16-cycle
// budget) share start/reset, each with its own PC model; run outcomes are predicted per launch.
module tb_run_ctrl;

  localparam int PL = 119;

  typedef struct {
    int kind;  // 0 normal end, 1 abort, 2 reset during run
    int cyc;
    int len;
    int tmo;
    int pcf;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        cr[2], pcl[2], dn[2], tmo[2], hlt[2];
  logic [15:0] cyc[2];
  logic [9:0]  pcv[2], pcc[2];

  bit          stuck;
  logic [9:0]  stuck_p;
  bit          halt_en;
  logic [9:0]  halt_pc;

  int r_stuck, r_p, r_hen, r_h, r_aen, r_a;
  int n_chk = 0;
  int n_fail = 0;

  exp_t q0[$];
  exp_t q1[$];
  exp_t cur[2];
  bit   have[2];
  bit   prev_cr[2];
  int   run_len[2];

  always #5 clk = ~clk;

  run_ctrl u_dut0 (
    .clk(clk), .reset(reset), .start(start), .pc(pcv[0]), .halt_i(hlt[0]),
    .core_run(cr[0]), .pc_clear(pcl[0]), .done(dn[0]), .timeout(tmo[0]), .cycles(cyc[0])
  );

  run_ctrl #(.TIMEOUT(16)) u_dut1 (
    .clk(clk), .reset(reset), .start(start), .pc(pcv[1]), .halt_i(hlt[1]),
    .core_run(cr[1]), .pc_clear(pcl[1]), .done(dn[1]), .timeout(tmo[1]), .cycles(cyc[1])
  );

  // Fetch-stage stand-in: PC advances while running unless the current instruction halts.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (pcl[i] === 1'b1) pcc[i] <= '0;
      else if (cr[i] === 1'b1 && !hlt[i]) pcc[i] <= pcc[i] + 10'd1;
    end
  end

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      pcv[i] = stuck ? stuck_p : pcc[i];
      hlt[i] = halt_en && (pcv[i] == halt_pc);
    end
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic exp_t predict(input int t);
    exp_t e;
    int   last, tc;
    e.kind = 0;
    if (r_stuck != 0) begin
      tc = t; e.tmo = 1; e.pcf = r_p;
    end else begin
      last = (r_hen != 0 && r_h < PL) ? r_h : PL;
      if (last + 1 <= t) begin
        tc = last + 1; e.tmo = 0;
        e.pcf = (r_hen != 0 && r_h <= PL) ? r_h : PL + 1;
      end else begin
        tc = t; e.tmo = 1; e.pcf = t;
      end
    end
    e.cyc = tc;
    e.len = tc;
    if (r_aen != 0 && r_a <= tc) begin
      e.kind = 1; e.cyc = r_a; e.len = r_a; e.tmo = 0;
    end
    return e;
  endfunction

  task automatic setp(input int s, input int p, input int hen, input int h,
                      input int aen, input int a);
    r_stuck = s; r_p = p; r_hen = hen; r_h = h; r_aen = aen; r_a = a;
    stuck   = (s != 0);
    stuck_p = 10'(p);
    halt_en = (hen != 0);
    halt_pc = 10'(h);
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int t = 0; t < 5000; t++) begin
      @(negedge clk);
      if (cr[0] !== 1'b1 && cr[1] !== 1'b1) begin ok = 1'b1; break; end
    end
    if (!ok) chk("run_end_wait_expired", 1, 0);
  endtask

  task automatic run_one();
    q0.push_back(predict(4096));
    q1.push_back(predict(16));
    @(negedge clk) start = 1'b0;
    @(posedge clk);
    if (r_aen != 0) begin
      repeat (r_a - 1) @(posedge clk);
      @(negedge clk) start = 1'b1;
    end
    wait_idle();
    @(negedge clk) start = 1'b1;
    repeat ($urandom_range(1, 3)) @(negedge clk);
  endtask

  task automatic reset_mid(input int c);
    exp_t e;
    setp(0, 0, 0, 0, 0, 0);
    e.kind = 2; e.cyc = 0; e.len = c; e.tmo = 0; e.pcf = 0;
    q0.push_back(e);
    q1.push_back(e);
    @(negedge clk) start = 1'b0;
    @(posedge clk);
    repeat (c - 1) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    @(negedge clk) reset = 1'b1;
    repeat (6) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("d%0d_postrst_core_run", i), cr[i], 0);
      chk($sformatf("d%0d_postrst_pc_clear", i), pcl[i], 1);
      chk($sformatf("d%0d_postrst_done", i), dn[i], 0);
      chk($sformatf("d%0d_postrst_cycles", i), cyc[i], 0);
    end
    start = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  // Monitor: pops an expectation when a run starts, checks it when the run ends.
  initial begin
    for (int i = 0; i < 2; i++) begin have[i] = 0; prev_cr[i] = 0; run_len[i] = 0; end
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (cr[i] === 1'b1 && !prev_cr[i]) begin
          have[i] = 1'b0;
          if (i == 0 && q0.size() > 0) begin cur[i] = q0.pop_front(); have[i] = 1'b1; end
          if (i == 1 && q1.size() > 0) begin cur[i] = q1.pop_front(); have[i] = 1'b1; end
          if (!have[i]) chk($sformatf("d%0d_unexpected_run", i), 1, 0);
          run_len[i] = 0;
          chk($sformatf("d%0d_rise_done", i), dn[i], 0);
          chk($sformatf("d%0d_rise_pc_clear", i), pcl[i], 0);
          chk($sformatf("d%0d_rise_cycles", i), cyc[i], 0);
          chk($sformatf("d%0d_rise_timeout", i), tmo[i], 0);
        end
        if (cr[i] === 1'b1) run_len[i]++;
        if (cr[i] !== 1'b1 && prev_cr[i] && have[i]) begin
          chk($sformatf("d%0d_run_length", i), run_len[i], cur[i].len);
          chk($sformatf("d%0d_end_cycles", i), cyc[i], cur[i].cyc);
          chk($sformatf("d%0d_end_timeout", i), tmo[i], cur[i].tmo);
          chk($sformatf("d%0d_end_done", i), dn[i], (cur[i].kind == 0) ? 1 : 0);
          chk($sformatf("d%0d_end_pc_clear", i), pcl[i], (cur[i].kind == 0) ? 0 : 1);
          if (cur[i].kind == 0) chk($sformatf("d%0d_end_pc", i), pcv[i], cur[i].pcf);
          have[i] = 1'b0;
        end
        prev_cr[i] = (cr[i] === 1'b1);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k;
    reset = 1'b0;
    start = 1'b1;
    setp(0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("d%0d_rst_core_run", i), cr[i], 0);
      chk($sformatf("d%0d_rst_pc_clear", i), pcl[i], 1);
      chk($sformatf("d%0d_rst_done", i), dn[i], 0);
      chk($sformatf("d%0d_rst_timeout", i), tmo[i], 0);
      chk($sformatf("d%0d_rst_cycles", i), cyc[i], 0);
    end
    reset = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("d%0d_armed_pc_clear", i), pcl[i], 1);
      chk($sformatf("d%0d_armed_done", i), dn[i], 0);
    end

    setp(0, 0, 0, 0, 0, 0);  run_one();
    setp(0, 0, 1, 5, 0, 0);  run_one();
    setp(1, 3, 0, 0, 0, 0);  run_one();
    setp(0, 0, 0, 0, 1, 10); run_one();
    setp(0, 0, 0, 0, 0, 0);  run_one();
    setp(0, 0, 1, 15, 0, 0); run_one();
    setp(0, 0, 1, 5, 1, 6);  run_one();
    setp(0, 0, 1, 0, 0, 0);  run_one();
    setp(0, 0, 0, 0, 1, 1);  run_one();
    setp(0, 0, 1, PL, 0, 0); run_one();
    setp(0, 0, 1, 16, 0, 0); run_one();
    reset_mid(5);

    for (int n = 0; n < 40; n++) begin
      k = $urandom_range(0, 3);
      case (k)
        0: setp(0, 0, 0, 0, 0, 0);
        1: setp(0, 0, 1, $urandom_range(0, 125), 0, 0);
        2: setp(0, 0, 0, 0, 1, $urandom_range(1, 20));
        default: setp(0, 0, 1, $urandom_range(0, 30), 1, $urandom_range(1, 30));
      endcase
      run_one();
    end

    repeat (5) @(negedge clk);
    chk("queue0_drained", q0.size(), 0);
    chk("queue1_drained", q1.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
